// File: rtl/jk_counter_reg.sv
// N-bit register of JK cells with JK, up, down and load modes on one clock.
// Define JK_COUNTER_SAT_EN to make the counter modes saturate instead of wrapping.
module jk_counter_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             TC
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] lower_ones;
  logic [WIDTH-1:0] lower_zeros;
  logic             at_max;
  logic             at_min;
  logic             up_blocked;
  logic             down_blocked;

  assign at_max = &q_reg;
  assign at_min = ~|q_reg;

`ifdef JK_COUNTER_SAT_EN
  assign up_blocked   = at_max;
  assign down_blocked = at_min;
`else
  assign up_blocked   = 1'b0;
  assign down_blocked = 1'b0;
`endif

  // Ripple "all lower bits are 1 / are 0" chains drive the per-bit toggle enables.
  assign lower_ones[0]  = 1'b1;
  assign lower_zeros[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign lower_ones[gi]  = lower_ones[gi-1] & q_reg[gi-1];
      assign lower_zeros[gi] = lower_zeros[gi-1] & ~q_reg[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic j_eff;
      logic k_eff;

      always_comb begin
        j_eff = 1'b0;
        k_eff = 1'b0;
        if (EN) begin
          case (MODE)
            MODE_JK: begin
              j_eff = J[gi];
              k_eff = K[gi];
            end
            MODE_UP: begin
              j_eff = lower_ones[gi] & ~up_blocked;
              k_eff = lower_ones[gi] & ~up_blocked;
            end
            MODE_DOWN: begin
              j_eff = lower_zeros[gi] & ~down_blocked;
              k_eff = lower_zeros[gi] & ~down_blocked;
            end
            default: begin
              j_eff = J[gi];
              k_eff = ~J[gi];
            end
          endcase
        end
      end

      assign q_next[gi] = (j_eff & ~q_reg[gi]) | (~k_eff & q_reg[gi]);
    end
  endgenerate

  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q  = q_reg;
  assign QN = ~q_reg;

  // Gated by Clr so a cleared register in down mode does not report terminal count.
  assign TC = ~Clr & EN & (((MODE == MODE_UP) & at_max) | ((MODE == MODE_DOWN) & at_min));

endmodule

// File: tb/tb_jk_counter_reg.sv
// Directed bench for jk_counter_reg at WIDTH=4; expectations follow JK_COUNTER_SAT_EN.
module tb_jk_counter_reg;

  localparam int W = 4;

  logic         CLK;
  logic         Clr;
  logic         EN;
  logic [1:0]   MODE;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic [W-1:0] Q;
  logic [W-1:0] QN;
  logic         TC;

  int checks;
  int errors;

  jk_counter_reg #(.WIDTH(W)) dut (
    .CLK(CLK), .Clr(Clr), .EN(EN), .MODE(MODE),
    .J(J), .K(K), .Q(Q), .QN(QN), .TC(TC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [W-1:0] val);
    EN = 1'b1; MODE = 2'b11; J = val; K = 4'b0000;
    tick();
  endtask

  task automatic test_reset();
    Clr = 1'b1; EN = 1'b1; MODE = 2'b10; J = '0; K = '0;
    #2;
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL reset_q: got %b want 0000", Q); end
    checks++;
    if (QN !== 4'b1111) begin errors++; $display("FAIL reset_qn: got %b want 1111", QN); end
    checks++;
    if (TC !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want 0", TC); end
    tick();
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL reset_held: got %b want 0000", Q); end
    Clr = 1'b0;
    $display("test_reset: Q=%b QN=%b", Q, QN);
  endtask

  task automatic test_async_clear();
    load(4'b1010);
    checks++;
    if (Q !== 4'b1010) begin errors++; $display("FAIL aclr_load: got %b want 1010", Q); end
    MODE = 2'b10; EN = 1'b1;
    #1;
    Clr = 1'b1;
    #1;
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL aclr_q: got %b want 0000", Q); end
    checks++;
    if (QN !== 4'b1111) begin errors++; $display("FAIL aclr_qn: got %b want 1111", QN); end
    checks++;
    if (TC !== 1'b0) begin errors++; $display("FAIL aclr_tc: got %b want 0", TC); end
    Clr = 1'b0;
    $display("test_async_clear: Q=%b QN=%b TC=%b", Q, QN, TC);
  endtask

  task automatic test_jk_table();
    load(4'b0011);
    MODE = 2'b00; EN = 1'b1; J = 4'b0101; K = 4'b0110;
    tick();
    checks++;
    if (Q !== 4'b0101) begin errors++; $display("FAIL jk_table_q: got %b want 0101", Q); end
    checks++;
    if (QN !== 4'b1010) begin errors++; $display("FAIL jk_table_qn: got %b want 1010", QN); end
    checks++;
    if (TC !== 1'b0) begin errors++; $display("FAIL jk_table_tc: got %b want 0", TC); end
    $display("test_jk_table: Q=%b", Q);
  endtask

  task automatic test_jk_toggle();
    load(4'b1100);
    MODE = 2'b00; J = 4'b1111; K = 4'b1111;
    tick();
    checks++;
    if (Q !== 4'b0011) begin errors++; $display("FAIL jk_toggle_1: got %b want 0011", Q); end
    tick();
    checks++;
    if (Q !== 4'b1100) begin errors++; $display("FAIL jk_toggle_2: got %b want 1100", Q); end
    $display("test_jk_toggle: Q=%b", Q);
  endtask

  task automatic test_hold();
    load(4'b0110);
    EN = 1'b0; MODE = 2'b11; J = 4'b1001;
    tick();
    checks++;
    if (Q !== 4'b0110) begin errors++; $display("FAIL hold_load: got %b want 0110", Q); end
    MODE = 2'b00; J = 4'b1111; K = 4'b1111;
    tick();
    checks++;
    if (Q !== 4'b0110) begin errors++; $display("FAIL hold_jk: got %b want 0110", Q); end
    MODE = 2'b01; J = 4'b0000; K = 4'b0000;
    tick();
    checks++;
    if (Q !== 4'b0110) begin errors++; $display("FAIL hold_up: got %b want 0110", Q); end
    $display("test_hold: Q=%b", Q);
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] exp_q [3];
    logic         exp_tc [3];
`ifdef JK_COUNTER_SAT_EN
    exp_q  = '{4'b1111, 4'b1111, 4'b1111};
    exp_tc = '{1'b1, 1'b1, 1'b1};
`else
    exp_q  = '{4'b1111, 4'b0000, 4'b0001};
    exp_tc = '{1'b1, 1'b0, 1'b0};
`endif
    load(4'b1110);
    MODE = 2'b01; EN = 1'b1;
    #1;
    checks++;
    if (TC !== 1'b0) begin errors++; $display("FAIL up_tc_pre: got %b want 0", TC); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Q !== exp_q[i]) begin errors++; $display("FAIL up_q[%0d]: got %b want %b", i, Q, exp_q[i]); end
      checks++;
      if (TC !== exp_tc[i]) begin errors++; $display("FAIL up_tc[%0d]: got %b want %b", i, TC, exp_tc[i]); end
      $display("test_up_wrap: step %0d Q=%b TC=%b", i, Q, TC);
    end
  endtask

  task automatic test_down_wrap();
    logic         en_seq [4];
    logic [W-1:0] exp_q [4];
    logic         exp_tc [4];
    en_seq = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef JK_COUNTER_SAT_EN
    exp_q  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    exp_tc = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_q  = '{4'b0000, 4'b1111, 4'b1111, 4'b1110};
    exp_tc = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
    load(4'b0001);
    MODE = 2'b10;
    for (int i = 0; i < 4; i++) begin
      EN = en_seq[i];
      #1;
      checks++;
      if (TC !== exp_tc[i]) begin errors++; $display("FAIL down_tc[%0d]: got %b want %b", i, TC, exp_tc[i]); end
      tick();
      checks++;
      if (Q !== exp_q[i]) begin errors++; $display("FAIL down_q[%0d]: got %b want %b", i, Q, exp_q[i]); end
      $display("test_down_wrap: step %0d EN=%b Q=%b", i, en_seq[i], Q);
    end
  endtask

  task automatic test_clear_during_count();
    load(4'b0000);
    MODE = 2'b01; EN = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (Q !== 4'b0101) begin errors++; $display("FAIL cnt_reach: got %b want 0101", Q); end
    Clr = 1'b1;
    #1;
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL cnt_clr: got %b want 0000", Q); end
    Clr = 1'b0;
    tick();
    checks++;
    if (Q !== 4'b0001) begin errors++; $display("FAIL cnt_after_clr: got %b want 0001", Q); end
    $display("test_clear_during_count: Q=%b", Q);
  endtask

  task automatic test_back_to_back();
    load(4'b0010);
    MODE = 2'b01;
    tick();
    checks++;
    if (Q !== 4'b0011) begin errors++; $display("FAIL b2b_up: got %b want 0011", Q); end
    MODE = 2'b11; J = 4'b1001; K = 4'b1111;
    tick();
    checks++;
    if (Q !== 4'b1001) begin errors++; $display("FAIL b2b_load: got %b want 1001", Q); end
    MODE = 2'b10;
    tick();
    checks++;
    if (Q !== 4'b1000) begin errors++; $display("FAIL b2b_down: got %b want 1000", Q); end
    MODE = 2'b00; J = 4'b0001; K = 4'b1000;
    tick();
    checks++;
    if (Q !== 4'b0001) begin errors++; $display("FAIL b2b_jk: got %b want 0001", Q); end
    $display("test_back_to_back: Q=%b", Q);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Clr = 1'b1; EN = 1'b0; MODE = 2'b00; J = '0; K = '0;
    test_reset();
    test_async_clear();
    test_jk_table();
    test_jk_toggle();
    test_hold();
    test_up_wrap();
    test_down_wrap();
    test_clear_during_count();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
